// File: rtl/fir_pkg.sv
// ============================================================================
// Module      : fir_pkg
// Description : Shared constants, types and helpers for the FIR coefficient
//               scheduler (kernel geometry, coefficient format, FSM states).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fir_pkg;

    localparam int TAPS      = 5;
    localparam int NCOEFF    = TAPS * TAPS;
    localparam int COEFF_W   = 16;
    localparam int FRAC_BITS = 8;

    typedef logic signed [COEFF_W-1:0] coeff_t;
    typedef logic [4:0]                idx_t;

    // Centre of the kernel carries the unity gain tap in the identity kernel.
    localparam idx_t CENTRE_IDX = idx_t'(NCOEFF / 2);
    localparam idx_t LAST_IDX   = idx_t'(NCOEFF - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CLEAR   = 2'd1,
        PENDING = 2'd2
    } sched_state_t;

    // Identity kernel: 1.0 (in fixed point) at the centre, zero elsewhere.
    function automatic coeff_t identity_coeff(input idx_t k);
        coeff_t v;
        v = '0;
        if (k == CENTRE_IDX) begin
            v = coeff_t'(1 << FRAC_BITS);
        end
        return v;
    endfunction

endpackage

`default_nettype wire

// File: rtl/fir_coeff_scheduler_if.sv
// ============================================================================
// Module      : fir_coeff_scheduler_if
// Description : Configuration port of the coefficient scheduler. The master
//               side (register decoder) issues coefficient writes with a
//               valid/ready handshake plus commit/clear/error-clear pulses.
// Signals     : cfg_wr_valid, cfg_wr_ready, cfg_wr_idx, cfg_wr_data,
//               cfg_commit, cfg_clear, cfg_err_clr
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface fir_coeff_scheduler_if;
    import fir_pkg::*;

    logic   cfg_wr_valid;
    logic   cfg_wr_ready;
    idx_t   cfg_wr_idx;
    coeff_t cfg_wr_data;
    logic   cfg_commit;
    logic   cfg_clear;
    logic   cfg_err_clr;

    modport master (
        output cfg_wr_valid,
        input  cfg_wr_ready,
        output cfg_wr_idx,
        output cfg_wr_data,
        output cfg_commit,
        output cfg_clear,
        output cfg_err_clr
    );

    modport slave (
        input  cfg_wr_valid,
        output cfg_wr_ready,
        input  cfg_wr_idx,
        input  cfg_wr_data,
        input  cfg_commit,
        input  cfg_clear,
        input  cfg_err_clr
    );

endinterface

`default_nettype wire

// File: rtl/sync_edge_det.sv
// ============================================================================
// Module      : sync_edge_det
// Description : Qualifies a level against its active polarity, registers it,
//               and emits a one-cycle pulse on the inactive->active transition.
// Ports       : clk     - clock, rising edge
//               rst     - asynchronous, active-low reset
//               level_i - raw level input
//               rise_o  - high for the cycle the level first becomes active
// Params      : ACT_LEVEL - input value considered "active"
//               RST_LEVEL - value held by the history register in reset; set
//                           to 1 so an input already active at reset release
//                           does not register as an edge
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_edge_det #(
    parameter logic ACT_LEVEL = 1'b1,
    parameter logic RST_LEVEL = 1'b1
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic level_i,
    output logic      rise_o
);

    logic act;
    logic act_q;

    assign act = (level_i == ACT_LEVEL);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            act_q <= RST_LEVEL;
        end else begin
            act_q <= act;
        end
    end

    assign rise_o = act & ~act_q;

endmodule

`default_nettype wire

// File: rtl/fir_coeff_scheduler.sv
// ============================================================================
// Module      : fir_coeff_scheduler
// Description : Double-buffered coefficient bank for the 5x5 systolic FIR.
//               Writes land in a shadow bank; a commit arms a copy of the
//               shadow into the active bank at the next vertical-sync rising
//               edge so the kernel never changes mid-frame.
// Ports       : clk         - pixel clock
//               rst         - asynchronous, active-low reset
//               cfg         - configuration interface (slave modport)
//               vs_i        - vertical sync
//               coeff_o     - active bank, tap k at [k*COEFF_W +: COEFF_W]
//               pending_o   - commit armed, waiting for frame boundary
//               swap_o      - one-cycle pulse with the first new coeff_o
//               err_o       - sticky out-of-range write index flag
//               frame_cnt_o - frame counter
// Build macro : FIR_FRAME_CNT_EN - when defined, frame_cnt_o counts every
//               vs rising edge (wrapping); otherwise it is tied to zero.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fir_coeff_scheduler
    import fir_pkg::*;
#(
    parameter logic VS_POL = 1'b1
) (
    input  wire logic                        clk,
    input  wire logic                        rst,
    fir_coeff_scheduler_if.slave             cfg,
    input  wire logic                        vs_i,
    output logic [NCOEFF*COEFF_W-1:0]        coeff_o,
    output logic                             pending_o,
    output logic                             swap_o,
    output logic                             err_o,
    output logic [15:0]                      frame_cnt_o
);

    sched_state_t state_q, state_d;
    idx_t         clr_cnt_q, clr_cnt_d;
    coeff_t       shadow_q [NCOEFF];
    coeff_t       active_q [NCOEFF];
    logic         swap_q;
    logic         err_q, err_d;

    logic         vs_rise;
    logic         wr_ready;
    logic         wr_fire;
    logic         wr_in_range;
    logic         do_swap;

    sync_edge_det #(
        .ACT_LEVEL (VS_POL),
        .RST_LEVEL (1'b1)
    ) u_vs_edge (
        .clk     (clk),
        .rst     (rst),
        .level_i (vs_i),
        .rise_o  (vs_rise)
    );

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            clr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and control outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = '0;
        wr_ready  = 1'b0;
        pending_o = 1'b0;
        do_swap   = 1'b0;

        case (state_q)
            IDLE: begin
                wr_ready = 1'b1;
                // Clear wins over commit when both arrive together.
                if (cfg.cfg_clear) begin
                    state_d = CLEAR;
                end else if (cfg.cfg_commit) begin
                    state_d = PENDING;
                end
            end

            CLEAR: begin
                if (clr_cnt_q == LAST_IDX) begin
                    state_d = IDLE;
                end else begin
                    clr_cnt_d = clr_cnt_q + idx_t'(1);
                end
            end

            PENDING: begin
                pending_o = 1'b1;
                if (vs_rise) begin
                    do_swap = 1'b1;
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign cfg.cfg_wr_ready = wr_ready;
    assign wr_fire          = cfg.cfg_wr_valid & wr_ready;
    assign wr_in_range      = (cfg.cfg_wr_idx <= LAST_IDX);

    // ------------------------------------------------------------------
    // Shadow bank: host writes in IDLE, identity walk in CLEAR
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < NCOEFF; k++) begin
                shadow_q[k] <= identity_coeff(idx_t'(k));
            end
        end else if (state_q == CLEAR) begin
            shadow_q[clr_cnt_q] <= identity_coeff(clr_cnt_q);
        end else if (wr_fire && wr_in_range) begin
            shadow_q[cfg.cfg_wr_idx] <= cfg.cfg_wr_data;
        end
    end

    // ------------------------------------------------------------------
    // Active bank: only reset or a frame-boundary swap may change it
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < NCOEFF; k++) begin
                active_q[k] <= identity_coeff(idx_t'(k));
            end
            swap_q <= 1'b0;
        end else begin
            if (do_swap) begin
                for (int k = 0; k < NCOEFF; k++) begin
                    active_q[k] <= shadow_q[k];
                end
            end
            swap_q <= do_swap;
        end
    end

    // Set takes priority over clear so a same-cycle bad write is never lost.
    always_comb begin
        err_d = err_q;
        if (cfg.cfg_err_clr) begin
            err_d = 1'b0;
        end
        if (wr_fire && !wr_in_range) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign swap_o = swap_q;
    assign err_o  = err_q;

    for (genvar k = 0; k < NCOEFF; k++) begin : g_pack
        assign coeff_o[k*COEFF_W +: COEFF_W] = active_q[k];
    end

`ifdef FIR_FRAME_CNT_EN
    logic [15:0] frame_cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            frame_cnt_q <= '0;
        end else if (vs_rise) begin
            frame_cnt_q <= frame_cnt_q + 16'd1;
        end
    end

    assign frame_cnt_o = frame_cnt_q;
`else
    assign frame_cnt_o = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fir_coeff_scheduler.sv
`default_nettype none

module tb_fir_coeff_scheduler;
    import fir_pkg::*;

    localparam int BW = NCOEFF * COEFF_W;
    typedef logic [BW-1:0] bank_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        vs_i = 1'b1;
    bank_t       coeff_o;
    logic        pending_o;
    logic        swap_o;
    logic        err_o;
    logic [15:0] frame_cnt_o;

    int    checks = 0;
    int    errors = 0;
    int    swaps  = 0;
    int    frames = 0;
    int    s0;
    int    n;
    int    exp_frames;
    bank_t model;
    bank_t sb_q[$];

    always #5 clk = ~clk;

    fir_coeff_scheduler_if cfg_if ();

    fir_coeff_scheduler #(
        .VS_POL (1'b1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cfg         (cfg_if),
        .vs_i        (vs_i),
        .coeff_o     (coeff_o),
        .pending_o   (pending_o),
        .swap_o      (swap_o),
        .err_o       (err_o),
        .frame_cnt_o (frame_cnt_o)
    );

    function automatic bank_t ident();
        bank_t b;
        b = '0;
        b[12*COEFF_W +: COEFF_W] = 16'h0100;
        return b;
    endfunction

    task automatic check_bank(input string tag, input bank_t obs, input bank_t exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input int idx, input logic [15:0] data);
        int w;
        cfg_if.cfg_wr_valid = 1'b1;
        cfg_if.cfg_wr_idx   = idx_t'(idx);
        cfg_if.cfg_wr_data  = data;
        w = 0;
        while (!cfg_if.cfg_wr_ready && w < 200) begin
            tick();
            w++;
        end
        if (w >= 200) check_val("wr_ready_timeout", 32'(w), 32'(0));
        tick();
        cfg_if.cfg_wr_valid = 1'b0;
        if (idx < 25) model[idx*COEFF_W +: COEFF_W] = data;
    endtask

    task automatic do_commit();
        cfg_if.cfg_commit = 1'b1;
        tick();
        cfg_if.cfg_commit = 1'b0;
        sb_q.push_back(model);
    endtask

    task automatic vs_pulse();
        vs_i = 1'b1;
        tick();
        frames++;
        vs_i = 1'b0;
        tick();
    endtask

    // Scoreboard consumer: every swap pulse must match the bank committed.
    always @(negedge clk) begin
        bank_t e;
        if (swap_o) begin
            swaps++;
            if (sb_q.size() == 0) begin
                check_val("unexpected_swap", 32'(1), 32'(0));
            end else begin
                e = sb_q.pop_front();
                check_bank("swap_bank", coeff_o, e);
                check_val("swap_pending_low", 32'(pending_o), 32'(0));
            end
        end
    end

    initial begin
        cfg_if.cfg_wr_valid = 1'b0;
        cfg_if.cfg_wr_idx   = '0;
        cfg_if.cfg_wr_data  = '0;
        cfg_if.cfg_commit   = 1'b0;
        cfg_if.cfg_clear    = 1'b0;
        cfg_if.cfg_err_clr  = 1'b0;
        model = ident();

        // Reset with vs held active through release
        rst  = 1'b0;
        vs_i = 1'b1;
        repeat (3) tick();
        rst = 1'b1;
        repeat (10) tick();
        check_bank("reset_coeff", coeff_o, ident());
        check_val("reset_pending", 32'(pending_o), 32'(0));
        check_val("reset_err", 32'(err_o), 32'(0));
        check_val("reset_ready", 32'(cfg_if.cfg_wr_ready), 32'(1));
        check_val("vs_high_no_swap", 32'(swaps), 32'(0));
        check_val("vs_high_no_frame", 32'(frame_cnt_o), 32'(0));
        vs_i = 1'b0;
        tick();

        // Basic write + commit, held off until frame boundary
        do_write(0, 16'hFFFF);
        do_write(24, 16'h0040);
        do_commit();
        repeat (100) tick();
        check_bank("hold_coeff", coeff_o, ident());
        check_val("hold_pending", 32'(pending_o), 32'(1));
        check_val("hold_ready", 32'(cfg_if.cfg_wr_ready), 32'(0));
        s0 = swaps;
        vs_pulse();
        check_val("swap_count_1", 32'(swaps), 32'(s0 + 1));
        check_val("swap_one_cycle", 32'(swap_o), 32'(0));
        check_val("coeff0", 32'(coeff_o[0 +: 16]), 32'(16'hFFFF));
        check_val("coeff24", 32'(coeff_o[24*16 +: 16]), 32'(16'h0040));
        check_val("post_swap_pending", 32'(pending_o), 32'(0));

        // Out-of-range index: accepted, dropped, sticky error
        do_write(30, 16'h1234);
        check_val("err_set", 32'(err_o), 32'(1));
        do_commit();
        s0 = swaps;
        vs_pulse();
        check_val("swap_count_err", 32'(swaps), 32'(s0 + 1));
        check_val("err_sticky", 32'(err_o), 32'(1));
        cfg_if.cfg_err_clr = 1'b1;
        tick();
        cfg_if.cfg_err_clr = 1'b0;
        check_val("err_clr", 32'(err_o), 32'(0));

        // Write and commit in the same cycle
        cfg_if.cfg_wr_valid = 1'b1;
        cfg_if.cfg_wr_idx   = idx_t'(5);
        cfg_if.cfg_wr_data  = 16'h7ABC;
        cfg_if.cfg_commit   = 1'b1;
        tick();
        cfg_if.cfg_wr_valid = 1'b0;
        cfg_if.cfg_commit   = 1'b0;
        model[5*COEFF_W +: COEFF_W] = 16'h7ABC;
        sb_q.push_back(model);
        check_val("wrcommit_pending", 32'(pending_o), 32'(1));
        vs_pulse();
        check_val("coeff5", 32'(coeff_o[5*16 +: 16]), 32'(16'h7ABC));

        // Non-identity kernel, then clear back to identity
        do_write(3, 16'h0011);
        do_write(12, 16'h0200);
        do_commit();
        vs_pulse();
        check_val("coeff12_loaded", 32'(coeff_o[12*16 +: 16]), 32'(16'h0200));
        cfg_if.cfg_clear = 1'b1;
        tick();
        cfg_if.cfg_clear = 1'b0;
        n = 0;
        while (!cfg_if.cfg_wr_ready && n < 60) begin
            n++;
            tick();
        end
        check_val("clear_cycles", 32'(n), 32'(25));
        check_val("clear_no_pending", 32'(pending_o), 32'(0));
        model = ident();
        do_commit();
        vs_pulse();
        check_bank("clear_identity", coeff_o, ident());
        check_val("queue_drained", 32'(sb_q.size()), 32'(0));

`ifdef FIR_FRAME_CNT_EN
        exp_frames = frames;
`else
        exp_frames = 0;
`endif
        check_val("frame_cnt_run", 32'(frame_cnt_o), 32'(exp_frames));

        // Reset while a swap is pending discards it
        do_write(0, 16'h1111);
        do_commit();
        check_val("pre_rst_pending", 32'(pending_o), 32'(1));
        rst = 1'b0;
        #2;
        check_bank("rst_pend_coeff", coeff_o, ident());
        check_val("rst_pend_pending", 32'(pending_o), 32'(0));
        check_val("rst_pend_swap", 32'(swap_o), 32'(0));
        check_val("rst_pend_frame", 32'(frame_cnt_o), 32'(0));
        tick();
        rst = 1'b1;
        sb_q.delete();
        model  = ident();
        frames = 0;
        s0     = swaps;
        tick();
        vs_pulse();
        vs_pulse();
        vs_pulse();
        check_val("rst_no_swap", 32'(swaps), 32'(s0));
        check_bank("rst_coeff_kept", coeff_o, ident());
`ifdef FIR_FRAME_CNT_EN
        exp_frames = frames;
`else
        exp_frames = 0;
`endif
        check_val("frame_cnt_3", 32'(frame_cnt_o), 32'(exp_frames));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/fir_coeff_scheduler.md
Name: fir_coeff_scheduler

Overview:
Controller that configures the 5x5 systolic FIR datapath. It holds a shadow coefficient bank written over a simple valid/ready config port, and an active bank that drives the filter. Shadow is copied to active only at a frame boundary (vertical-sync rising edge), so a kernel change never tears mid-frame. It sits between the MicroBlaze-side register decoder and the cascaded systolic FIR, in the clk (RX_CLK) domain.

Parameters:
TAPS, 5, kernel side length; NCOEFF = TAPS*TAPS = 25
COEFF_W, 16, signed coefficient width
FRAC_BITS, 8, fractional bits; identity centre tap = 1<<FRAC_BITS
VS_POL, 1, active level of vs_i (1 = active-high)

Ports:
clk  in  1  pixel clock; all logic on rising edge
rst  in  1  asynchronous, active-low reset
cfg_wr_valid  in  1  coefficient write request
cfg_wr_ready  out  1  write accepted when valid&ready
cfg_wr_idx  in  5  coefficient index, row*TAPS+col, 0..24
cfg_wr_data  in  COEFF_W  signed coefficient
cfg_commit  in  1  single-cycle pulse: request shadow->active swap at next frame
cfg_clear  in  1  single-cycle pulse: load identity kernel into shadow
cfg_err_clr  in  1  clears err_o
vs_i  in  1  vertical sync from the pixel stream
coeff_o  out  NCOEFF*COEFF_W  active bank, index k at bits [k*COEFF_W +: COEFF_W]
pending_o  out  1  commit requested, swap not yet done
swap_o  out  1  one-cycle pulse, cycle new coeff_o first valid
err_o  out  1  sticky: write with index >= 25
frame_cnt_o  out  16  frame counter (see Optional Feature)

Behaviour:
- Reset (rst=0, async): both banks = identity (index 12 = 1<<FRAC_BITS, rest 0); state IDLE; pending_o=0, swap_o=0, err_o=0, frame_cnt_o=0; vs_q = active level (no spurious edge on release).
- Edge detect: vs_act = (vs_i==VS_POL); vs_rise = vs_act & ~vs_q; vs_q <= vs_act each cycle.
- States: IDLE, CLEAR, PENDING.
- IDLE: cfg_wr_ready=1. Accepted write updates shadow[idx] at that clock edge (1-cycle latency); idx>=25 accepted, data dropped, err_o set. cfg_clear -> CLEAR (priority over commit). cfg_commit -> PENDING. Write + commit in same cycle: write lands, then PENDING (new value included in swap).
- CLEAR: cfg_wr_ready=0; 5-bit counter walks 0..24, one shadow entry per cycle to identity value; after index 24 -> IDLE (25 cycles). Commit during CLEAR ignored; clear during CLEAR ignored (no restart).
- PENDING: cfg_wr_ready=0, pending_o=1. On vs_rise: active <= shadow at that edge, swap_o=1 next cycle aligned with new coeff_o, -> IDLE. Commit/clear in PENDING ignored.
- vs_rise in IDLE/CLEAR: no bank change.
- Active bank changes only on swap or reset; coeff_o is registered, never combinational from shadow.
- err_o: set has priority over cfg_err_clr in the same cycle.
- Reset mid-CLEAR or mid-PENDING: all state and both banks return to reset values; pending swap is discarded.

Optional Feature:
FIR_FRAME_CNT_EN: when defined, frame_cnt_o increments (wrapping 0xFFFF->0) on every vs_rise regardless of state. When undefined, the counter is not built and frame_cnt_o is tied to 0.

Decomposition:
- Shared package fir_pkg: TAPS, NCOEFF, COEFF_W, FRAC_BITS constants; coeff_t (signed COEFF_W); idx_t (5-bit); sched_state_t enum {IDLE, CLEAR, PENDING}; identity-value function.
- One sub-module: sync_edge_det (registered level qualifier + rising-edge pulse, async active-low reset, reset level parameter), used for vs_i.

Test Plan:
- Reset then idle 10 cycles -> coeff_o index 12 = 0x0100, all other indices 0; pending_o=0, err_o=0.
- Write idx 0 = 0xFFFF, idx 24 = 0x0040, commit; no vs edge for 100 cycles -> coeff_o unchanged, pending_o=1, cfg_wr_ready=0; raise vs_i -> coeff_o[0]=0xFFFF, [24]=0x0040, swap_o high exactly 1 cycle, pending_o=0.
- Write idx 30 = 0x1234 -> handshake completes, err_o=1, shadow unchanged after commit+vs; cfg_err_clr -> err_o=0.
- Write idx 5 and commit in same cycle -> after vs_rise coeff_o[5] holds the written value.
- Load non-identity kernel, cfg_clear, commit, vs_rise -> cfg_wr_ready low exactly 25 cycles, then coeff_o back to identity.
- vs_i held high through reset release -> no swap_o, no frame count; with FIR_FRAME_CNT_EN, 3 vs pulses -> frame_cnt_o=3; assert rst while PENDING -> identity banks, pending_o=0, next vs gives no swap_o.
